ucnt_acc: RTL
=============

UCNT_ACC -- requirements
Module: ucnt_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the binary width of the operands feeding the upstream unary multiplier; window length CYCLE = 2^(WIDTH-1).
REQ-002 SHALL have parameter ACCW, default 16, meaning the partial-sum width (two's complement).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1 bit: request to open a new accumulation window.
REQ-006 SHALL have port i_psum, input, ACCW bits: incoming signed partial sum, sampled with i_start.
REQ-007 SHALL have port i_sign, input, 1 bit: product sign (1 = subtract), sampled with i_start.
REQ-008 SHALL have port i_bit, input, 1 bit: unary product bit from the upstream multiplier.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream accepts o_psum.
REQ-010 SHALL have port o_mul_en, output, 1 bit: high while bits are being counted; drives upstream multiplier enable.
REQ-011 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port o_valid, output, 1 bit: o_psum holds a finished result.
REQ-013 SHALL have port o_psum, output, ACCW bits: outgoing signed partial sum.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with i_start=1 at an edge, latch i_psum and i_sign, clear ones counter and cycle counter, and enter RUN.
REQ-016 SHALL, in IDLE with i_start=0, remain in IDLE.
REQ-017 SHALL, in RUN, on each edge add i_bit to a WIDTH-bit ones counter (range 0..CYCLE, no overflow) and increment the cycle counter.
REQ-018 SHALL count exactly CYCLE bits: bits sampled at edges k+1..k+CYCLE where i_start was sampled at edge k; after edge k+CYCLE the state is DONE.
REQ-019 SHALL drive o_mul_en = 1 exactly while in RUN; 0 otherwise.
REQ-020 SHALL ignore i_start while in RUN.
REQ-021 SHALL, in DONE, drive o_valid=1 and o_psum = latched psum + ones (i_sign=0) or latched psum - ones (i_sign=1), ones zero-extended to ACCW, result modulo 2^ACCW (wrap, no saturation).
REQ-022 SHALL hold o_valid and o_psum stable in DONE until i_ready=1 at an edge.
REQ-023 SHALL, in DONE with i_ready=1 and i_start=0, go to IDLE; with i_ready=1 and i_start=1, latch new i_psum/i_sign, clear counters and go directly to RUN (back-to-back, no idle cycle).
REQ-024 SHALL, in DONE with i_ready=0, ignore i_start.
REQ-025 SHALL drive o_psum = 0 whenever o_valid = 0.
REQ-026 SHALL give result latency CYCLE+1 edges from i_start sample to first cycle with o_valid=1... precisely: o_valid rises after edge k+CYCLE.

Reset
REQ-027 SHALL, when rst=1 at an edge, enter IDLE, clear all counters and latched values, regardless of state (including mid-RUN or DONE awaiting i_ready).
REQ-028 SHALL drive o_mul_en=0, o_busy=0, o_valid=0, o_psum=0 in the cycle after reset and until a new i_start.
REQ-029 SHALL give rst priority over i_start and i_ready in the same cycle.

Verification
REQ-030 SHALL cover: WIDTH=8, i_psum=0, i_sign=0, i_bit=1 for all 128 RUN cycles -> o_valid after edge k+128, o_psum=128.
REQ-031 SHALL cover: i_psum=-5, i_bit=0 throughout -> o_psum=-5 (0xFFFB).
REQ-032 SHALL cover: i_psum=100, i_sign=1, i_bit alternating 1,0 (64 ones) -> o_psum=36.
REQ-033 SHALL cover: i_psum=32767, i_sign=0, exactly one 1 bit -> o_psum=-32768 (wrap).
REQ-034 SHALL cover: i_ready held 0 for 10 cycles in DONE then 1 with i_start=1, i_psum=7 -> o_psum stable for 10 cycles, next cycle o_valid=0, o_mul_en=1, new window yields 7+ones.
REQ-035 SHALL cover: rst=1 at RUN cycle 50 -> next cycle all outputs 0, state IDLE; a following i_start produces a correct fresh result unaffected by earlier bits.

Source files
------------

// File: rtl/ucnt_acc.sv
// Unary-product accumulator: counts ones from an upstream unary multiplier over a
// 2^(WIDTH-1)-cycle window and adds/subtracts the count to a latched partial sum.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | counting i_bit, upstream multiplier enabled
// DONE  | result valid on o_psum, waiting for i_ready
module ucnt_acc #(
    parameter int WIDTH = 8,
    parameter int ACCW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [ACCW-1:0] i_psum,
    input  logic            i_sign,
    input  logic            i_bit,
    input  logic            i_ready,
    output logic            o_mul_en,
    output logic            o_busy,
    output logic            o_valid,
    output logic [ACCW-1:0] o_psum
);

    localparam int CYCLE = 1 << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  ones_cnt;
    logic [WIDTH-1:0]  cyc_cnt;
    logic [ACCW-1:0]   psum_q;
    logic              sign_q;

    logic [WIDTH-1:0]  ones_next;
    logic [ACCW-1:0]   ones_ext;
    logic              last_bit;

    // The final bit is folded in on the terminal edge so the result is registered with o_valid.
    assign ones_next = ones_cnt + WIDTH'(i_bit);
    assign ones_ext  = ACCW'(ones_next);
    assign last_bit  = (cyc_cnt == WIDTH'(CYCLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ones_cnt <= '0;
            cyc_cnt  <= '0;
            psum_q   <= '0;
            sign_q   <= 1'b0;
            o_mul_en <= 1'b0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_psum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= RUN;
                        psum_q   <= i_psum;
                        sign_q   <= i_sign;
                        ones_cnt <= '0;
                        cyc_cnt  <= '0;
                        o_mul_en <= 1'b1;
                        o_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    ones_cnt <= ones_next;
                    cyc_cnt  <= cyc_cnt + WIDTH'(1);
                    if (last_bit) begin
                        state    <= DONE;
                        o_mul_en <= 1'b0;
                        o_valid  <= 1'b1;
                        o_psum   <= sign_q ? (psum_q - ones_ext) : (psum_q + ones_ext);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_psum  <= '0;
                        if (i_start) begin
                            state    <= RUN;
                            psum_q   <= i_psum;
                            sign_q   <= i_sign;
                            ones_cnt <= '0;
                            cyc_cnt  <= '0;
                            o_mul_en <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_mul_en <= 1'b0;
                    o_busy   <= 1'b0;
                    o_valid  <= 1'b0;
                    o_psum   <= '0;
                end
            endcase
        end
    end

endmodule
